serdes_ser_gearbox: RTL and testbench

Parametrised single-clock serializer for the SERDES transmit path. It accepts parallel words on a valid/ready handshake and emits them as SER_WIDTH-bit beats, one beat per sclk cycle, in a configurable bit order. A one-word holding buffer allows gapless back-to-back streaming. It succeeds the fixed 1-bit, dual-clock serializer; pclk-to-sclk crossing is done upstream in a CDC FIFO.

---
 rtl/serdes_ser_gearbox.sv | 91 +++++++++
 tb/tb_serdes_ser_gearbox.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/serdes_ser_gearbox.sv
// Single-clock parallel-to-serial gearbox with a one-word holding buffer for gapless streaming.
// Define SERDES_SER_IDLE_FILL_EN to drive IDLE_PATTERN on sdata_out whenever no word is shifting.
module serdes_ser_gearbox #(
  parameter int DATA_WIDTH = 8,
  parameter int SER_WIDTH = 1,
  parameter bit MSB_FIRST = 1'b0,
  parameter logic [SER_WIDTH-1:0] IDLE_PATTERN = '0
) (
  input  logic                  sclk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] pdata_in,
  input  logic                  pdata_valid,
  output logic                  pdata_ready,
  output logic [SER_WIDTH-1:0]  sdata_out,
  output logic                  sdata_valid,
  output logic                  sdata_sof,
  output logic                  busy
);

  localparam int BEATS = DATA_WIDTH / SER_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  if (DATA_WIDTH % SER_WIDTH != 0) begin : g_bad_width
    $error("serdes_ser_gearbox: SER_WIDTH must divide DATA_WIDTH");
  end

`ifdef SERDES_SER_IDLE_FILL_EN
  localparam logic [SER_WIDTH-1:0] IDLE_OUT = IDLE_PATTERN;
`else
  localparam logic [SER_WIDTH-1:0] IDLE_OUT = IDLE_PATTERN & '0;
`endif

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shift_word;
  logic [DATA_WIDTH-1:0] hold_word;
  logic [DATA_WIDTH-1:0] load_word;
  logic [CNT_W-1:0]      beat_cnt;
  logic                  hold_valid;
  logic                  accept;

  function automatic logic [SER_WIDTH-1:0] beat_of(input logic [DATA_WIDTH-1:0] w, input int k);
    int shamt;
    shamt = MSB_FIRST ? DATA_WIDTH - (k + 1) * SER_WIDTH : k * SER_WIDTH;
    beat_of = SER_WIDTH'(w >> shamt);
  endfunction

  assign pdata_ready = !hold_valid;
  assign accept      = pdata_valid && pdata_ready;
  assign busy        = (state == SHIFT) || hold_valid;
  assign load_word   = hold_valid ? hold_word : pdata_in;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shift_word  <= '0;
      hold_word   <= '0;
      hold_valid  <= 1'b0;
      beat_cnt    <= '0;
      sdata_out   <= '0;
      sdata_valid <= 1'b0;
      sdata_sof   <= 1'b0;
    end else if (state == SHIFT && beat_cnt != LAST_BEAT) begin
      beat_cnt  <= beat_cnt + CNT_W'(1);
      sdata_out <= beat_of(shift_word, int'(beat_cnt) + 1);
      sdata_sof <= 1'b0;
      if (accept) begin
        hold_word  <= pdata_in;
        hold_valid <= 1'b1;
      end
    end else if (hold_valid || accept) begin
      // IDLE accept and last-beat reload share this path so beat 0 timing is identical
      state       <= SHIFT;
      shift_word  <= load_word;
      hold_valid  <= 1'b0;
      beat_cnt    <= '0;
      sdata_out   <= beat_of(load_word, 0);
      sdata_valid <= 1'b1;
      sdata_sof   <= 1'b1;
    end else begin
      state       <= IDLE;
      beat_cnt    <= '0;
      sdata_out   <= IDLE_OUT;
      sdata_valid <= 1'b0;
      sdata_sof   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serdes_ser_gearbox.sv
// Scoreboard bench for serdes_ser_gearbox: three instances (1-bit LSB-first, 2-bit MSB-first, 8-bit single beat)
// driven with directed and random words; a model expands each accepted word into its expected beats.
`timescale 1ns/1ps
module tb_serdes_ser_gearbox;

  localparam int DW = 8;
  localparam int NINST = 3;

  logic sclk = 1'b0;
  always #5 sclk = ~sclk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s (inst %0d) at %0t: got 0x%0h, expected 0x%0h", name, inst, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < NINST; g++) begin : g_inst
    localparam int SW = (g == 0) ? 1 : (g == 1) ? 2 : 8;
    localparam bit MSB = (g == 1);
    localparam int BEATS = DW / SW;
    localparam logic [SW-1:0] IDLE_PAT = '1;

    logic          rst_n;
    logic [DW-1:0] pdata_in;
    logic          pdata_valid;
    logic          pdata_ready;
    logic [SW-1:0] sdata_out;
    logic          sdata_valid;
    logic          sdata_sof;
    logic          busy;
    logic          edge_seen;
    bit            fin = 1'b0;

    logic [SW-1:0] exp_data[$];
    int            exp_idx[$];

    serdes_ser_gearbox #(
      .DATA_WIDTH(DW), .SER_WIDTH(SW), .MSB_FIRST(MSB), .IDLE_PATTERN(IDLE_PAT)
    ) dut (
      .sclk(sclk), .rst_n(rst_n), .pdata_in(pdata_in), .pdata_valid(pdata_valid),
      .pdata_ready(pdata_ready), .sdata_out(sdata_out), .sdata_valid(sdata_valid),
      .sdata_sof(sdata_sof), .busy(busy)
    );

    always @(posedge sclk or negedge rst_n) begin
      if (!rst_n) edge_seen <= 1'b0;
      else        edge_seen <= 1'b1;
    end

    // Beat k gathers SW consecutive bits counted from the chosen end of the word
    function automatic logic [SW-1:0] model_beat(input logic [DW-1:0] w, input int k);
      logic [SW-1:0] b;
      int base;
      base = MSB ? DW - (k + 1) * SW : k * SW;
      for (int i = 0; i < SW; i++) b[i] = w[base + i];
      return b;
    endfunction

    function automatic logic [SW-1:0] idle_exp();
`ifdef SERDES_SER_IDLE_FILL_EN
      return edge_seen ? IDLE_PAT : '0;
`else
      return '0;
`endif
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge plus gap cycles
    task automatic send(input logic [DW-1:0] w, input int gap);
      int budget;
      budget = 64;
      pdata_in = w;
      pdata_valid = 1'b1;
      while (!pdata_ready && budget > 0) begin
        @(posedge sclk);
        #1;
        budget--;
      end
      if (budget == 0) check("accept_timeout", g, 32'd0, 32'd1);
      @(posedge sclk);
      for (int k = 0; k < BEATS; k++) begin
        exp_data.push_back(model_beat(w, k));
        exp_idx.push_back(k);
      end
      #1;
      pdata_valid = 1'b0;
      repeat (gap) begin
        @(posedge sclk);
        #1;
      end
    endtask

    task automatic applyStimulus();
      rst_n = 1'b0;
      pdata_valid = 1'b0;
      pdata_in = '0;
      repeat (3) @(posedge sclk);
      #1;
      rst_n = 1'b1;
      @(posedge sclk);
      #1;
      if (g == 0) begin
        send(8'hA5, 12);
        send(8'h12, 0);
        send(8'h34, 0);
        send(8'h56, 10);
      end else if (g == 1) begin
        send(8'hB4, 6);
      end else begin
        for (int i = 0; i < 4; i++) send(8'(8'h3C + i * 8'h11), 0);
        repeat (3) begin @(posedge sclk); #1; end
      end
      for (int i = 0; i < 40; i++) begin
        send(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 12)));
      end
      repeat (BEATS + 2) begin @(posedge sclk); #1; end
      if (g == 0) begin
        // 0xFF shifting with 0xC3 in hold, reset while beat 3 is on the wire
        send(8'hFF, 0);
        send(8'hC3, 0);
        @(posedge sclk);
        @(posedge sclk);
        #2;
        pdata_in = 8'h99;
        pdata_valid = 1'b1;
        rst_n = 1'b0;
        exp_data.delete();
        exp_idx.delete();
        #1;
        check("rst_sdata_valid", g, 32'(sdata_valid), 32'd0);
        check("rst_sdata_sof", g, 32'(sdata_sof), 32'd0);
        check("rst_sdata_out", g, 32'(sdata_out), 32'd0);
        check("rst_busy", g, 32'(busy), 32'd0);
        check("rst_pdata_ready", g, 32'(pdata_ready), 32'd1);
        repeat (3) @(posedge sclk);
        #1;
        pdata_valid = 1'b0;
        rst_n = 1'b1;
        send(8'h0F, 12);
      end
      fin = 1'b1;
    endtask

    initial applyStimulus();

    task automatic checkOutput();
      int remaining;
      if (!rst_n) begin
        check("reset_valid", g, 32'(sdata_valid), 32'd0);
        check("reset_sof", g, 32'(sdata_sof), 32'd0);
        check("reset_out", g, 32'(sdata_out), 32'd0);
        check("reset_busy", g, 32'(busy), 32'd0);
        check("reset_ready", g, 32'(pdata_ready), 32'd1);
      end else if (exp_data.size() == 0) begin
        check("idle_valid", g, 32'(sdata_valid), 32'd0);
        check("idle_sof", g, 32'(sdata_sof), 32'd0);
        check("idle_out", g, 32'(sdata_out), 32'(idle_exp()));
        check("idle_busy", g, 32'(busy), 32'd0);
        check("idle_ready", g, 32'(pdata_ready), 32'd1);
      end else begin
        // A second queued word beyond the current one means it sits in the holding buffer
        remaining = BEATS - exp_idx[0];
        check("beat_valid", g, 32'(sdata_valid), 32'd1);
        check("beat_sof", g, 32'(sdata_sof), 32'(exp_idx[0] == 0));
        check("beat_data", g, 32'(sdata_out), 32'(exp_data[0]));
        check("beat_busy", g, 32'(busy), 32'd1);
        check("beat_ready", g, 32'(pdata_ready), 32'(exp_data.size() <= remaining));
        void'(exp_data.pop_front());
        void'(exp_idx.pop_front());
      end
    endtask

    initial begin
      forever begin
        @(negedge sclk);
        checkOutput();
      end
    end
  end

  initial begin
    int cycles;
    cycles = 0;
    while (!(g_inst[0].fin && g_inst[1].fin && g_inst[2].fin) && cycles < 20000) begin
      @(posedge sclk);
      cycles++;
    end
    check("all_streams_done", 0, 32'(g_inst[0].fin && g_inst[1].fin && g_inst[2].fin), 32'd1);
    repeat (4) @(posedge sclk);
    check("queue_drained", 0, 32'(g_inst[0].exp_data.size()), 32'd0);
    check("queue_drained", 1, 32'(g_inst[1].exp_data.size()), 32'd0);
    check("queue_drained", 2, 32'(g_inst[2].exp_data.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
